// File: rtl/recip_pkg.sv
// Shared widths, FSM state encoding and reciprocal seed table for the
// Newton-Raphson reciprocal sequencer.
package recip_pkg;

  localparam int M_W = 24;  // mantissa, Q1.23
  localparam int Y_W = 17;  // reciprocal estimate, Q1.16
  localparam int P_W = 48;  // multiplier product
  localparam int X_W = 25;  // multiplier X operand

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_MUL_T,
    S_MUL_Y,
    S_DONE
  } state_t;

  // round(65536 / (1 + (i + 0.5) / 16)): reciprocal at the centre of each
  // 1/16-wide mantissa interval.
  localparam logic [Y_W-1:0] SEED_ROM [16] = '{
    17'h0F83E, 17'h0EA0F, 17'h0DD68, 17'h0D20D,
    17'h0C7CE, 17'h0BE83, 17'h0B60B, 17'h0AE4C,
    17'h0A72F, 17'h0A0A1, 17'h09A91, 17'h094F2,
    17'h08FB8, 17'h08AD9, 17'h0864C, 17'h08208
  };

  // 2.0 in Q2.39
  localparam logic [P_W-1:0] TWO_Q239 = 48'd2 << 39;

endpackage

// File: rtl/recip_seed_rom.sv
// Seed lookup: top four fraction bits of the mantissa select a 17-bit
// Q1.16 initial reciprocal estimate. Purely combinational.
//   i_idx  : m[22:19]
//   o_seed : y0, Q1.16
module recip_seed_rom
  import recip_pkg::*;
(
  input  logic [3:0]     i_idx,
  output logic [Y_W-1:0] o_seed
);

  assign o_seed = SEED_ROM[i_idx];

endmodule

// File: rtl/newton_recip_seq.sv
// Iterative Newton-Raphson reciprocal of a normalized mantissa in [1,2),
// result in Q1.16. Drives an external unsigned hard multiplier whose product
// becomes valid MUL_LAT cycles after the operands are presented.
//   clk, Rst                      : clock, async active-high reset
//   in_valid/in_ready/in_m        : mantissa input handshake (Q1.23)
//   out_valid/out_ready           : result handshake
//   out_recip/out_err             : 1/m (Q1.16), non-normalized input flag
//   mul_x/mul_y/mul_ce/mul_p      : hard multiplier request/response
module newton_recip_seq
  import recip_pkg::*;
#(
  parameter int ITER    = 2,
  parameter int MUL_LAT = 0
) (
  input  logic           clk,
  input  logic           Rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M_W-1:0] in_m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Y_W-1:0] out_recip,
  output logic           out_err,
  output logic [X_W-1:0] mul_x,
  output logic [Y_W-1:0] mul_y,
  output logic           mul_ce,
  input  logic [P_W-1:0] mul_p
);

  localparam logic [2:0] LAT       = 3'(MUL_LAT);
  localparam logic [1:0] ITER_LAST = 2'(ITER - 1);

  state_t         r_state, w_next;
  logic [M_W-1:0] r_m;
  logic [Y_W-1:0] r_y;
  logic [2:0]     r_phase;
  logic [1:0]     r_iter;
  logic [Y_W-1:0] r_recip;
  logic           r_err;
  logic [X_W-1:0] r_mul_x;
  logic [Y_W-1:0] r_mul_y;
  logic           r_mul_ce;

  logic [Y_W-1:0] w_seed;
  logic           w_phase_end;
  logic [Y_W-1:0] w_e;
  logic [Y_W:0]   w_rnd;
  logic [Y_W-1:0] w_ynew;

  recip_seed_rom u_rom (
    .i_idx  (r_m[22:19]),
    .o_seed (w_seed)
  );

  assign w_phase_end = (r_phase == LAT);
  // e = 2 - m*y, Q2.39 -> Q1.16
  assign w_e   = 17'((TWO_Q239 - mul_p) >> 23);
  // e*y is Q2.32; round to Q1.16 and clamp at 1.0
  assign w_rnd = {1'b0, mul_p[32:16]} + {17'b0, mul_p[15]};
  assign w_ynew = ((mul_p[47:33] != '0) || (w_rnd > 18'h10000)) ? 17'h10000
                                                                 : w_rnd[16:0];

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_recip = r_recip;
  assign out_err   = r_err;
  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;
  assign mul_ce    = r_mul_ce;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = in_m[23] ? S_SEED : S_DONE;
      S_SEED:  w_next = S_MUL_T;
      S_MUL_T: if (w_phase_end) w_next = S_MUL_Y;
      S_MUL_Y: if (w_phase_end) w_next = (r_iter == ITER_LAST) ? S_DONE : S_MUL_T;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands and mul_ce are loaded on the edge that enters each multiply
  // phase, so they are stable for the whole phase and mul_ce stays high
  // across back-to-back phases.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_m      <= '0;
      r_y      <= '0;
      r_phase  <= '0;
      r_iter   <= '0;
      r_recip  <= '0;
      r_err    <= 1'b0;
      r_mul_x  <= '0;
      r_mul_y  <= '0;
      r_mul_ce <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_m <= in_m;
            if (!in_m[23]) begin
              r_recip <= 17'h1FFFF;
              r_err   <= 1'b1;
            end
          end
        end
        S_SEED: begin
          r_y      <= w_seed;
          r_mul_x  <= {1'b0, r_m};
          r_mul_y  <= w_seed;
          r_mul_ce <= 1'b1;
          r_phase  <= '0;
          r_iter   <= '0;
        end
        S_MUL_T: begin
          if (w_phase_end) begin
            r_mul_x <= {8'b0, w_e};
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + 3'd1;
          end
        end
        S_MUL_Y: begin
          if (w_phase_end) begin
            r_y     <= w_ynew;
            r_phase <= '0;
            if (r_iter == ITER_LAST) begin
              r_mul_ce <= 1'b0;
              r_recip  <= w_ynew;
              r_err    <= 1'b0;
            end else begin
              r_mul_x <= {1'b0, r_m};
              r_mul_y <= w_ynew;
              r_iter  <= r_iter + 2'd1;
            end
          end else begin
            r_phase <= r_phase + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_newton_recip_seq.sv
module tb_newton_recip_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_m = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;   // 0: default instance, 1: MUL_LAT=2 instance

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // default instance (ITER=2, MUL_LAT=0)
  logic        ir0, ov0, oe0, ce0;
  logic [16:0] or0, my0;
  logic [24:0] mx0;
  logic [47:0] mp0;
  assign mp0 = 48'(mx0) * 48'(my0);

  newton_recip_seq u_dut0 (
    .clk(clk), .Rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(ir0), .in_m(in_m),
    .out_valid(ov0), .out_ready(out_ready), .out_recip(or0), .out_err(oe0),
    .mul_x(mx0), .mul_y(my0), .mul_ce(ce0), .mul_p(mp0)
  );

  // MUL_LAT=2 instance with a two-stage multiplier model
  logic        ir2, ov2, oe2, ce2;
  logic [16:0] or2, my2;
  logic [24:0] mx2;
  logic [47:0] mp2, pipe1;
  always @(posedge clk) begin
    pipe1 <= 48'(mx2) * 48'(my2);
    mp2   <= pipe1;
  end

  newton_recip_seq #(.ITER(2), .MUL_LAT(2)) u_dut2 (
    .clk(clk), .Rst(rst),
    .in_valid(in_valid & sel), .in_ready(ir2), .in_m(in_m),
    .out_valid(ov2), .out_ready(out_ready), .out_recip(or2), .out_err(oe2),
    .mul_x(mx2), .mul_y(my2), .mul_ce(ce2), .mul_p(mp2)
  );

  logic        w_in_ready, w_out_valid, w_out_err, w_mul_ce;
  logic [16:0] w_out_recip;
  assign w_in_ready  = sel ? ir2 : ir0;
  assign w_out_valid = sel ? ov2 : ov0;
  assign w_out_err   = sel ? oe2 : oe0;
  assign w_mul_ce    = sel ? ce2 : ce0;
  assign w_out_recip = sel ? or2 : or0;

  // Stimulus only: runs one operation, holds out_ready low for 'hold' cycles
  // once the result appears, and reports what was seen.
  task automatic do_op(input logic [23:0] m, input int hold,
                       output logic [16:0] r, output logic e,
                       output int lat, output int ce_cnt, output int bad);
    bad = 0;
    ce_cnt = 0;
    @(negedge clk);
    in_m = m;
    in_valid = 1'b1;
    out_ready = 1'b0;
    if (w_in_ready !== 1'b1) bad++;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (w_out_valid !== 1'b1 && lat < 200) begin
      if (w_mul_ce === 1'b1) ce_cnt++;
      @(negedge clk);
      lat++;
    end
    r = w_out_recip;
    e = w_out_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (w_out_valid !== 1'b1 || w_out_recip !== r || w_out_err !== e ||
          w_in_ready !== 1'b0) bad++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", oe0); end
    checks++; if (ce0 !== 1'b0) begin errors++; $display("FAIL reset_mul_ce got %b want 0", ce0); end
    checks++; if (or0 !== 17'h0) begin errors++; $display("FAIL reset_out_recip got %h want 00000", or0); end
    checks++; if (mx0 !== 25'h0 || my0 !== 17'h0) begin errors++; $display("FAIL reset_mul_xy got %h/%h want 0/0", mx0, my0); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ir0 !== 1'b1 || ir2 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b/%b want 1/1", ir0, ir2); end
  endtask

  task automatic test_unity();
    logic [16:0] r; logic e; int lat, cc, bad;
    do_op(24'h800000, 0, r, e, lat, cc, bad);
    checks++; if (lat !== 6) begin errors++; $display("FAIL unity_latency got %0d want 6", lat); end
    checks++; if (r !== 17'h10000) begin errors++; $display("FAIL unity_recip got %h want 10000", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL unity_err got %b want 0", e); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL unity_handshake got %0d bad want 0", bad); end
  endtask

  task automatic test_values();
    logic [16:0] r; logic e; int lat, cc, bad, d;
    do_op(24'hC00000, 0, r, e, lat, cc, bad);
    d = int'(r) - int'(17'h0AAAB);
    checks++; if (d > 1 || d < -1) begin errors++; $display("FAIL recip_1p5 got %h want 0AAAB+-1", r); end
    checks++; if (lat !== 6 || e !== 1'b0) begin errors++; $display("FAIL recip_1p5_lat_err got %0d/%b want 6/0", lat, e); end
    do_op(24'hFFFFFF, 0, r, e, lat, cc, bad);
    d = int'(r) - int'(17'h08000);
    checks++; if (d > 1 || d < -1) begin errors++; $display("FAIL recip_max got %h want 08000+-1", r); end
    checks++; if (cc !== 4) begin errors++; $display("FAIL mul_ce_cycles got %0d want 4", cc); end
  endtask

  task automatic test_error();
    logic [16:0] r; logic e; int lat, cc, bad;
    do_op(24'h41070D, 0, r, e, lat, cc, bad);
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency got %0d want 1", lat); end
    checks++; if (r !== 17'h1FFFF) begin errors++; $display("FAIL err_recip got %h want 1FFFF", r); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", e); end
    checks++; if (cc !== 0) begin errors++; $display("FAIL err_mul_ce got %0d want 0", cc); end
  endtask

  task automatic test_backpressure();
    logic [16:0] r; logic e; int lat, cc, bad, d;
    do_op(24'hA00000, 5, r, e, lat, cc, bad);
    d = int'(r) - int'(17'h0CCCD);
    checks++; if (d > 1 || d < -1) begin errors++; $display("FAIL recip_1p25 got %h want 0CCCD+-1", r); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad want 0", bad); end
  endtask

  task automatic test_mul_lat2();
    logic [16:0] r; logic e; int lat, cc, bad, d;
    sel = 1'b1;
    do_op(24'hC00000, 0, r, e, lat, cc, bad);
    sel = 1'b0;
    checks++; if (lat !== 14) begin errors++; $display("FAIL lat2_latency got %0d want 14", lat); end
    d = int'(r) - int'(17'h0AAAB);
    checks++; if (d > 1 || d < -1) begin errors++; $display("FAIL lat2_recip got %h want 0AAAB+-1", r); end
    checks++; if (cc !== 12) begin errors++; $display("FAIL lat2_mul_ce got %0d want 12", cc); end
  endtask

  task automatic test_reset_mid_op();
    logic [16:0] r; logic e; int lat, cc, bad, seen;
    @(negedge clk);
    in_m = 24'hC00000;
    in_valid = 1'b1;
    @(negedge clk);              // accepted, SEED
    in_valid = 1'b0;
    @(negedge clk);              // MUL_T
    @(negedge clk);              // MUL_Y
    checks++; if (ce0 !== 1'b1 || mx0[24:17] !== 8'h0) begin errors++; $display("FAIL mid_in_mul_y got ce=%b x=%h want ce=1 x<2^17", ce0, mx0); end
    rst = 1'b1;
    #1;
    checks++; if (ir0 !== 1'b1 || ce0 !== 1'b0 || ov0 !== 1'b0) begin errors++; $display("FAIL mid_reset got rdy=%b ce=%b ov=%b want 1/0/0", ir0, ce0, ov0); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov0 === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_valid got %0d want 0", seen); end
    do_op(24'h800000, 0, r, e, lat, cc, bad);
    checks++; if (r !== 17'h10000 || lat !== 6) begin errors++; $display("FAIL after_reset got %h lat %0d want 10000 lat 6", r, lat); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_values();
    test_error();
    test_backpressure();
    test_mul_lat2();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
